// File: rtl/nes_bus_pkg.sv
// -----------------------------------------------------------------------------
// nes_bus_pkg : shared types and default regions for the CPU memory bus.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package nes_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_HANDOFF = 2'd2
  } bus_state_e;

  localparam logic [15:0] WRAM_BASE = 16'h0000;
  localparam logic [15:0] WRAM_MASK = 16'hE000;
  localparam logic [15:0] PPU_BASE  = 16'h2000;
  localparam logic [15:0] PPU_MASK  = 16'hE000;
  localparam logic [15:0] PRG_BASE  = 16'h8000;
  localparam logic [15:0] PRG_MASK  = 16'h8000;

  // Index width that stays at least one bit for single-entry sets.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter : combinational fixed-priority / round-robin winner select.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module bus_rr_arbiter
  import nes_bus_pkg::*;
#(
  parameter int N       = 2,
  parameter int RR_MODE = 0,
  parameter int IW      = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan upward from the start index, wrapping; fixed priority starts at 0.
  always_comb begin
    int start;
    int j;
    logic [IW-1:0] jj;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    start   = (RR_MODE != 0) ? int'(rr_ptr_i) : 0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < N; i++) begin
      j = start + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!valid_o && req_i[jj]) begin
        valid_o   = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_bus_arb.sv
// -----------------------------------------------------------------------------
// cpu_bus_arb : N-master CPU bus arbiter with region decode and read return.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module cpu_bus_arb
  import nes_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_REGIONS = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int RR_MODE     = 0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {PRG_BASE, PPU_BASE, WRAM_BASE},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {PRG_MASK, PPU_MASK, WRAM_MASK}
) (
  input  logic                          clk_in,
  input  logic                          nres_in,
  input  logic [NUM_MASTERS-1:0]        m_req_in,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_a_in,
  input  logic [NUM_MASTERS-1:0]        m_r_nw_in,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_d_in,
  output logic [NUM_MASTERS-1:0]        m_gnt_out,
  output logic [DATA_W-1:0]             m_d_out,
  output logic [NUM_MASTERS-1:0]        m_rvalid_out,
  output logic [ADDR_W-1:0]             a_out,
  output logic                          r_nw_out,
  output logic [DATA_W-1:0]             d_out,
  output logic [NUM_REGIONS-1:0]        s_en_out,
  input  logic [NUM_REGIONS*DATA_W-1:0] s_d_in,
  output logic                          dec_err_out
);

  localparam int MIW = idx_w(NUM_MASTERS);
  localparam int RIW = idx_w(NUM_REGIONS);

  bus_state_e             state_q, state_d;
  logic [MIW-1:0]         owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic                   rd_pend_q, rd_pend_d, rd_hit_q, rd_hit_d;
  logic [RIW-1:0]         rd_reg_q, rd_reg_d;
  logic [MIW-1:0]         rd_own_q, rd_own_d;

  logic [NUM_MASTERS-1:0] win_oh;
  logic [MIW-1:0]         win_idx;
  logic                   win_vld;
  logic                   owned, owner_req, hit;
  logic [RIW-1:0]         hit_idx;

  bus_rr_arbiter #(
    .N       (NUM_MASTERS),
    .RR_MODE (RR_MODE),
    .IW      (MIW)
  ) u_arb (
    .req_i    (m_req_in),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (win_oh),
    .idx_o    (win_idx),
    .valid_o  (win_vld)
  );

  always_ff @(posedge clk_in) begin
    if (!nres_in) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_hit_q  <= 1'b0;
      rd_reg_q  <= '0;
      rd_own_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      rd_pend_q <= rd_pend_d;
      rd_hit_q  <= rd_hit_d;
      rd_reg_q  <= rd_reg_d;
      rd_own_q  <= rd_own_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    case (state_q)
      ST_IDLE, ST_HANDOFF: begin
        if (win_vld) begin
          state_d = ST_OWNED;
          owner_d = win_idx;
          gnt_d   = win_oh;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      ST_OWNED: begin
        // No preemption: only the owner's own release ends the tenure.
        if (!owner_req) begin
          state_d  = ST_HANDOFF;
          gnt_d    = '0;
          rr_ptr_d = (int'(owner_q) == NUM_MASTERS - 1) ? '0 : owner_q + MIW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    // Read return is keyed to the accepting cycle, independent of release.
    rd_pend_d = owned && r_nw_out;
    rd_hit_d  = hit;
    rd_reg_d  = hit_idx;
    rd_own_d  = owner_q;
  end

  always_comb begin
    owned     = (state_q == ST_OWNED);
    owner_req = m_req_in[owner_q];
    a_out     = '0;
    r_nw_out  = 1'b1;
    d_out     = '0;
    if (owned) begin
      a_out    = m_a_in[int'(owner_q)*ADDR_W +: ADDR_W];
      r_nw_out = m_r_nw_in[owner_q];
      d_out    = m_d_in[int'(owner_q)*DATA_W +: DATA_W];
    end
    hit     = 1'b0;
    hit_idx = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if ((a_out & REGION_MASK[r*ADDR_W +: ADDR_W]) == REGION_BASE[r*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = RIW'(r);
      end
    end
    s_en_out = '0;
    if (owned && hit) s_en_out[hit_idx] = 1'b1;
    dec_err_out  = owned && !hit;
    m_d_out      = (rd_pend_q && rd_hit_q) ? s_d_in[int'(rd_reg_q)*DATA_W +: DATA_W] : '0;
    m_rvalid_out = '0;
    if (rd_pend_q) m_rvalid_out[rd_own_q] = 1'b1;
    m_gnt_out = gnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_arb : directed self-checking bench for cpu_bus_arb.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_cpu_bus_arb;

  logic clk = 1'b0;
  logic nres;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Default instance: 2 masters, fixed priority, 3 regions
  logic [1:0]  req, rnw, gnt, rv;
  logic [31:0] a;
  logic [15:0] d;
  logic [7:0]  md, dout;
  logic [15:0] ao;
  logic        rnwo, derr;
  logic [2:0]  sen;
  logic [23:0] sd;

  cpu_bus_arb dut (
    .clk_in(clk), .nres_in(nres), .m_req_in(req), .m_a_in(a), .m_r_nw_in(rnw),
    .m_d_in(d), .m_gnt_out(gnt), .m_d_out(md), .m_rvalid_out(rv), .a_out(ao),
    .r_nw_out(rnwo), .d_out(dout), .s_en_out(sen), .s_d_in(sd), .dec_err_out(derr)
  );

  // Round-robin instance: 3 masters
  logic [2:0]  rreq, rrnw, rgnt, rrv;
  logic [47:0] ra;
  logic [23:0] rd;
  logic [7:0]  rmd, rdout;
  logic [15:0] rao;
  logic        rrnwo, rderr;
  logic [2:0]  rsen;
  logic [23:0] rsd;

  cpu_bus_arb #(.NUM_MASTERS(3), .RR_MODE(1)) dut_rr (
    .clk_in(clk), .nres_in(nres), .m_req_in(rreq), .m_a_in(ra), .m_r_nw_in(rrnw),
    .m_d_in(rd), .m_gnt_out(rgnt), .m_d_out(rmd), .m_rvalid_out(rrv), .a_out(rao),
    .r_nw_out(rrnwo), .d_out(rdout), .s_en_out(rsen), .s_d_in(rsd), .dec_err_out(rderr)
  );

  // Two-region instance without the PRG window
  logic [1:0]  dreq, drnw, dgnt, drv;
  logic [31:0] da;
  logic [15:0] dd;
  logic [7:0]  dmd, ddout;
  logic [15:0] dao;
  logic        drnwo, dderr;
  logic [1:0]  dsen;
  logic [15:0] dsd;

  cpu_bus_arb #(
    .NUM_REGIONS(2),
    .REGION_BASE({16'h2000, 16'h0000}),
    .REGION_MASK({16'hE000, 16'hE000})
  ) dut_de (
    .clk_in(clk), .nres_in(nres), .m_req_in(dreq), .m_a_in(da), .m_r_nw_in(drnw),
    .m_d_in(dd), .m_gnt_out(dgnt), .m_d_out(dmd), .m_rvalid_out(drv), .a_out(dao),
    .r_nw_out(drnwo), .d_out(ddout), .s_en_out(dsen), .s_d_in(dsd), .dec_err_out(dderr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_g;
    nres = 1'b0;
    req = 2'b11; rnw = 2'b11; a = '0; d = '0; sd = {8'h33, 8'h22, 8'h11};
    rreq = '0; rrnw = '1; ra = '0; rd = '0; rsd = '0;
    dreq = '0; drnw = 2'b11; da = '0; dd = '0; dsd = {8'h22, 8'h11};

    // Reset held 3 cycles with all requests high
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_rnw", rnwo, 1'b1);
      chk("rst_sen", sen, 3'b000);
      chk("rst_rv", rv, 2'b00);
      chk("rst_md", md, 8'h00);
      chk("rst_ao", ao, 16'h0000);
    end
    nres = 1'b1;

    cyc(); #1; chk("first_gnt", gnt, 2'b01);
    req = 2'b00;
    cyc(); #1; chk("handoff_gnt", gnt, 2'b00);
    cyc(); req = 2'b10; #1; chk("idle_gnt", gnt, 2'b00);
    cyc(); req = 2'b11; #1; chk("m1_gnt", gnt, 2'b10);
    cyc(); #1; chk("nopreempt_a", gnt, 2'b10);
    cyc(); #1; chk("nopreempt_b", gnt, 2'b10);
    req = 2'b01;
    cyc(); #1;
    chk("ho_gnt", gnt, 2'b00);
    chk("ho_ao", ao, 16'h0000);
    chk("ho_rnw", rnwo, 1'b1);

    // Decode and read return on consecutive cycles
    cyc(); a[15:0] = 16'h0123; #1;
    chk("m0_gnt", gnt, 2'b01);
    chk("ao_0123", ao, 16'h0123);
    chk("sen_wram", sen, 3'b001);
    chk("derr_0", derr, 1'b0);
    chk("rv_none", rv, 2'b00);
    cyc(); a[15:0] = 16'h2002; #1;
    chk("md_11", md, 8'h11); chk("rv_11", rv, 2'b01); chk("sen_ppu", sen, 3'b010);
    cyc(); a[15:0] = 16'h8000; #1;
    chk("md_22", md, 8'h22); chk("rv_22", rv, 2'b01); chk("sen_prg", sen, 3'b100);
    cyc(); a[15:0] = 16'h4000; #1;
    chk("md_33", md, 8'h33); chk("rv_33", rv, 2'b01);
    chk("sen_none", sen, 3'b000); chk("derr_hole", derr, 1'b1);
    cyc(); a[15:0] = 16'h0005; rnw = 2'b10; d[7:0] = 8'hA5; #1;
    chk("md_err0", md, 8'h00); chk("rv_err", rv, 2'b01);
    chk("wr_ao", ao, 16'h0005); chk("wr_d", dout, 8'hA5); chk("wr_rnw", rnwo, 1'b0);
    chk("wr_sen", sen, 3'b001); chk("wr_derr", derr, 1'b0);

    // Read in last owned cycle, then handoff to master 1
    cyc(); a[15:0] = 16'h8001; rnw = 2'b11; req = 2'b10; #1;
    chk("wr_norv", rv, 2'b00); chk("wr_nomd", md, 8'h00);
    chk("last_sen", sen, 3'b100); chk("last_gnt", gnt, 2'b01);
    cyc(); #1;
    chk("rel_gnt", gnt, 2'b00); chk("rel_rv", rv, 2'b01);
    chk("rel_md", md, 8'h33); chk("rel_sen", sen, 3'b000);
    cyc(); #1;
    chk("new_gnt", gnt, 2'b10); chk("new_norv", rv, 2'b00);
    cyc(); #1;
    chk("m1_rv", rv, 2'b10); chk("m1_md", md, 8'h11);
    nres = 1'b0;
    cyc(); #1;
    chk("midrst_gnt", gnt, 2'b00); chk("midrst_rv", rv, 2'b00); chk("midrst_md", md, 8'h00);
    nres = 1'b1; req = 2'b00;

    // Round-robin: 2-cycle tenures, order 0,1,2,0
    cyc(); rreq = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp_g = 3'b001 << (k % 3);
      cyc(); #1; chk("rr_gnt_a", rgnt, exp_g);
      cyc(); #1; chk("rr_gnt_b", rgnt, exp_g);
      rreq = 3'b111 & ~exp_g;
      cyc(); #1; chk("rr_idle", rgnt, 3'b000);
      rreq = 3'b111;
    end
    rreq = 3'b000;

    // Two-region decode error
    cyc(); dreq = 2'b01; da[15:0] = 16'h8000;
    cyc(); #1;
    chk("de_gnt", dgnt, 2'b01); chk("de_err", dderr, 1'b1); chk("de_sen", dsen, 2'b00);
    cyc(); #1;
    chk("de_rv", drv, 2'b01); chk("de_md", dmd, 8'h00);
    da[15:0] = 16'h2000; #1;
    chk("de_ppu_sen", dsen, 2'b10); chk("de_ppu_err", dderr, 1'b0);
    cyc(); #1;
    chk("de_ppu_md", dmd, 8'h22); chk("de_ppu_rv", drv, 2'b01);
    dreq = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_bus_arb.md
# cpu_bus_arb

Parametrised multi-master arbiter and address decoder for the CPU memory bus (cpumc). It replaces the fixed two-way debug-break mux and the hard-coded slave enables with N masters, R decoded regions and registered grant. It enforces a one-cycle bus handoff and returns read data to the master that issued the read. It sits between the masters (rp2a03, hci, future DMA/loader) and the slaves (wram, cart PRG, ppu register interface).

## Interface
- NUM_MASTERS, 2, number of requesting masters; index 0 is highest fixed priority.
- NUM_REGIONS, 3, number of decoded slave regions.
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- RR_MODE, 0, 0 = fixed priority, 1 = round-robin on release.
- REGION_BASE, {16'h8000,16'h2000,16'h0000}, flat NUM_REGIONS*ADDR_W bases; region r is slice r.
- REGION_MASK, {16'h8000,16'hE000,16'hE000}, flat NUM_REGIONS*ADDR_W masks.
- clk_in  input  1  system clock; the only clock.
- nres_in  input  1  reset, synchronous, active-low.
- m_req_in  input  NUM_MASTERS  bus request; held for the whole tenure.
- m_a_in  input  NUM_MASTERS*ADDR_W  per-master address.
- m_r_nw_in  input  NUM_MASTERS  per-master 1 = read, 0 = write.
- m_d_in  input  NUM_MASTERS*DATA_W  per-master write data.
- m_gnt_out  output  NUM_MASTERS  one-hot grant, registered.
- m_d_out  output  DATA_W  read data, shared by all masters.
- m_rvalid_out  output  NUM_MASTERS  read-data-valid strobe to the issuing master.
- a_out  output  ADDR_W  muxed bus address.
- r_nw_out  output  1  muxed read/not-write.
- d_out  output  DATA_W  muxed write data.
- s_en_out  output  NUM_REGIONS  one-hot slave enable.
- s_d_in  input  NUM_REGIONS*DATA_W  slave read data; 1-cycle synchronous latency.
- dec_err_out  output  1  one-cycle pulse on an owned access that matches no region.

## Operation
- States: IDLE (no owner), OWNED (owner index held), HANDOFF (one dead cycle).
- IDLE: if any m_req_in, select a winner and go to OWNED. The grant is visible the next cycle.
- Winner selection:
  - RR_MODE=0: lowest requesting index wins.
  - RR_MODE=1: first requester at or after rr_ptr wins, scanning upward and wrapping at NUM_MASTERS. rr_ptr becomes owner+1 (mod NUM_MASTERS) on release.
- OWNED: the owner keeps the grant while its m_req_in stays high. There is no preemption, even by a higher-priority master. When the owner drops its request, go to HANDOFF.
- HANDOFF: all grants 0 and bus idle. Then go to OWNED with a new winner if any request is pending, else to IDLE.
- Bus outputs:
  - While OWNED: a_out, r_nw_out and d_out follow the owner's inputs combinationally.
  - Otherwise: a_out=0, r_nw_out=1, d_out=0, s_en_out=0.
- Decode: region r matches when (a_out & MASK_r) == BASE_r. If several regions match, the lowest r wins. s_en_out is asserted only while OWNED.
- No region matches while OWNED: s_en_out=0, dec_err_out=1 that cycle. A read returns 0 with rvalid still asserted.
- Read return:
  - A read accepted in cycle k captures the region index and owner index in registers.
  - In cycle k+1, m_d_out = the registered region's s_d_in slice and m_rvalid_out[registered owner]=1.
  - This holds even if the owner released in cycle k.
- When no read is pending, m_d_out=0. Its value is valid only with rvalid.
- Writes produce no rvalid.

## Timing
- Reset (nres_in low at a clk_in edge) sets:
  - state=IDLE, rr_ptr=0, m_gnt_out=0, m_rvalid_out=0, dec_err_out=0, pending-read flag 0.
  - Combinationally: a_out=0, r_nw_out=1, d_out=0, s_en_out=0, m_d_out=0.
- Reset mid-tenure or with a read pending drops the grant and discards the pending rvalid.
- Request-to-grant latency: 1 cycle from IDLE, 2 cycles through HANDOFF.
- Release-to-next-grant: req low in cycle k gives HANDOFF in k+1 and the new grant in k+2.
- Read latency: 1 cycle from s_en_out to m_rvalid_out.
- Back-to-back reads by one owner give rvalid on consecutive cycles.
- If the owner releases and a different master requests in the same cycle, the standard HANDOFF path applies.

## Structure
- Package nes_bus_pkg holds:
  - the state enum (IDLE/OWNED/HANDOFF);
  - default region localparams (WRAM 0x0000/0xE000, PPU 0x2000/0xE000, PRG 0x8000/0x8000);
  - the clog2-based index width function.
- Sub-module bus_rr_arbiter: given req, rr_ptr and RR_MODE, returns a one-hot winner and its index. Purely combinational; the FSM stays in cpu_bus_arb.

## Test plan
- Reset: hold nres_in low 3 cycles with all m_req_in=1 -> m_gnt_out=0, r_nw_out=1, s_en_out=0 throughout; first grant to master 0 one cycle after release.
- Fixed priority: RR_MODE=0, req=2'b10 then req=2'b11 at cycle 5 -> master 1 keeps grant (no preemption); after master 1 drops req, one HANDOFF cycle, then gnt=2'b01.
- Round-robin: RR_MODE=1, NUM_MASTERS=3, all requesting with 2-cycle tenures -> grant order 0,1,2,0 with one idle cycle between each.
- Decode/read: master 0 reads 0x0123, 0x2002, 0x8000 on consecutive cycles, with slaves returning 0x11/0x22/0x33 -> s_en_out 001,010,100; m_d_out 0x11,0x22,0x33 with m_rvalid_out[0] one cycle later.
- Read across release: owner reads 0x8001 in its last owned cycle -> rvalid to the old owner in HANDOFF cycle; new owner sees no rvalid.
- Decode error: NUM_REGIONS=2 (no PRG region), access 0x8000 -> dec_err_out pulse, s_en_out=0, read returns 0x00 with rvalid.
